// File: rtl/sha256_msg_feeder.sv
// sha256_msg_feeder
//   Host-side initiator for a SHA-256 round core. Takes one message as a byte
//   stream, applies the standard SHA-256 padding, writes each 512-bit block
//   to the core as 16 big-endian words, pulses go and waits for done. After
//   the last block it pulses digest_valid while the core's h0..h7 hold the
//   final digest.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, msg_empty        begin a message (IDLE only); msg_empty = zero length
//   in_data/in_valid/in_last/in_ready   byte stream, accepted on valid && ready
//   core_init               one-cycle core reinitialisation pulse
//   chipselect/write/address/writedata  core word write port
//   go, done                core start pulse / sticky completion
//   busy, digest_valid      status
module sha256_msg_feeder #(
    parameter int unsigned LEN_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        msg_empty,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        core_init,
    output logic        chipselect,
    output logic        write,
    output logic [3:0]  address,
    output logic [31:0] writedata,
    output logic        go,
    input  logic        done,
    output logic        busy,
    output logic        digest_valid
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StInit = 3'd1;
    localparam logic [2:0] StLoad = 3'd2;
    localparam logic [2:0] StPad  = 3'd3;
    localparam logic [2:0] StGo   = 3'd4;
    localparam logic [2:0] StGap  = 3'd5;
    localparam logic [2:0] StWait = 3'd6;
    localparam logic [2:0] StDone = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] byte_count_q, byte_count_d;
    logic [3:0]       word_idx_q, word_idx_d;
    logic [1:0]       byte_pos_q, byte_pos_d;     // bytes held in the packer
    logic [23:0]      packer_q, packer_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;             // word 15 of this block launched
    logic             final_q, final_d;           // current block is the last one
    logic             pad_pend_q, pad_pend_d;     // another padding block follows
    logic             marker_done_q, marker_done_d;  // 0x80 already emitted
    logic             len_blk_q, len_blk_d;       // this pad block carries the length
    logic             wr_q, wr_d;
    logic [3:0]       addr_q, addr_d;
    logic [31:0]      data_q, data_d;

    logic        accept;
    logic [31:0] packed_word;
    logic [31:0] marker_word;
    logic [31:0] pad_word;
    logic        len_this;
    logic [63:0] bit_len;

    assign accept      = in_valid && in_ready;
    assign packed_word = {packer_q, in_data};
    assign bit_len     = 64'({byte_count_q, 3'b000});

    // Partial word completed with the 0x80 marker, bytes left-aligned.
    always_comb begin
        marker_word = 32'h8000_0000;
        case (byte_pos_q)
            2'd1:    marker_word = {packer_q[7:0], 8'h80, 16'h0000};
            2'd2:    marker_word = {packer_q[15:0], 8'h80, 8'h00};
            2'd3:    marker_word = {packer_q, 8'h80};
            default: marker_word = 32'h8000_0000;
        endcase
    end

    // The length fits in this block only if the marker landed in word 13 or earlier.
    assign len_this = marker_done_q ? len_blk_q : (word_idx_q <= 4'd13);

    always_comb begin
        pad_word = 32'h0;
        if (!marker_done_q) begin
            pad_word = marker_word;
        end else if (len_blk_q && word_idx_q == 4'd14) begin
            pad_word = bit_len[63:32];
        end else if (len_blk_q && word_idx_q == 4'd15) begin
            pad_word = bit_len[31:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_count_d  = byte_count_q;
        word_idx_d    = word_idx_q;
        byte_pos_d    = byte_pos_q;
        packer_d      = packer_q;
        empty_d       = empty_q;
        full_d        = full_q;
        final_d       = final_q;
        pad_pend_d    = pad_pend_q;
        marker_done_d = marker_done_q;
        len_blk_d     = len_blk_q;
        wr_d          = 1'b0;
        addr_d        = addr_q;
        data_d        = data_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    byte_count_d  = '0;
                    word_idx_d    = 4'd0;
                    byte_pos_d    = 2'd0;
                    packer_d      = 24'h0;
                    empty_d       = msg_empty;
                    full_d        = 1'b0;
                    final_d       = 1'b0;
                    pad_pend_d    = 1'b0;
                    marker_done_d = 1'b0;
                    len_blk_d     = 1'b0;
                    state_d       = StInit;
                end
            end
            StInit: state_d = empty_q ? StPad : StLoad;
            StLoad: begin
                if (full_q) begin
                    state_d = StGo;
                end else if (accept) begin
                    byte_count_d = byte_count_q + 1'b1;
                    packer_d     = packed_word[23:0];
                    byte_pos_d   = byte_pos_q + 2'd1;
                    if (byte_pos_q == 2'd3) begin
                        wr_d       = 1'b1;
                        addr_d     = word_idx_q;
                        data_d     = packed_word;
                        word_idx_d = word_idx_q + 4'd1;
                        if (word_idx_q == 4'd15) begin
                            full_d = 1'b1;
                        end
                    end
                    if (in_last) begin
                        state_d = StPad;
                        // Message ends exactly on a block boundary: padding gets its own block.
                        if (byte_pos_q == 2'd3 && word_idx_q == 4'd15) begin
                            pad_pend_d = 1'b1;
                        end
                    end
                end
            end
            StPad: begin
                if (full_q) begin
                    state_d = StGo;
                end else begin
                    wr_d       = 1'b1;
                    addr_d     = word_idx_q;
                    data_d     = pad_word;
                    word_idx_d = word_idx_q + 4'd1;
                    if (!marker_done_q) begin
                        marker_done_d = 1'b1;
                        len_blk_d     = len_this;
                        byte_pos_d    = 2'd0;
                    end
                    if (word_idx_q == 4'd15) begin
                        full_d     = 1'b1;
                        final_d    = len_this;
                        pad_pend_d = !len_this;
                    end
                end
            end
            StGo:  state_d = StGap;
            StGap: state_d = StWait;
            StWait: begin
                if (done) begin
                    word_idx_d = 4'd0;
                    full_d     = 1'b0;
                    if (final_q) begin
                        state_d = StDone;
                    end else if (pad_pend_q) begin
                        pad_pend_d = 1'b0;
                        len_blk_d  = 1'b1;
                        state_d    = StPad;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            byte_count_q  <= '0;
            word_idx_q    <= 4'd0;
            byte_pos_q    <= 2'd0;
            packer_q      <= 24'h0;
            empty_q       <= 1'b0;
            full_q        <= 1'b0;
            final_q       <= 1'b0;
            pad_pend_q    <= 1'b0;
            marker_done_q <= 1'b0;
            len_blk_q     <= 1'b0;
            wr_q          <= 1'b0;
            addr_q        <= 4'd0;
            data_q        <= 32'h0;
        end else begin
            state_q       <= state_d;
            byte_count_q  <= byte_count_d;
            word_idx_q    <= word_idx_d;
            byte_pos_q    <= byte_pos_d;
            packer_q      <= packer_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            final_q       <= final_d;
            pad_pend_q    <= pad_pend_d;
            marker_done_q <= marker_done_d;
            len_blk_q     <= len_blk_d;
            wr_q          <= wr_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
        end
    end

    assign in_ready     = (state_q == StLoad) && !full_q;
    assign core_init    = (state_q == StInit);
    assign chipselect   = wr_q;
    assign write        = wr_q;
    assign address      = addr_q;
    assign writedata    = data_q;
    assign go           = (state_q == StGo);
    assign busy         = (state_q != StIdle);
    assign digest_valid = (state_q == StDone);

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: a behavioural SHA-256 core (word capture,
// compression on go, sticky done) plus directed messages.
module tb_sha256_msg_feeder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        msg_empty = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        core_init;
    logic        chipselect;
    logic        write;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic        go;
    logic        done = 1'b0;
    logic        busy;
    logic        digest_valid;

    sha256_msg_feeder #(.LEN_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .msg_empty    (msg_empty),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .core_init    (core_init),
        .chipselect   (chipselect),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .go           (go),
        .done         (done),
        .busy         (busy),
        .digest_valid (digest_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Core model state
    logic [31:0] hh [8];
    logic [31:0] cur [16];
    logic [31:0] blocks [2][16];
    logic [7:0]  msg [64];
    int          wr_cnt = 0;
    int          go_cnt = 0;
    int          dv_cnt = 0;
    int          init_cnt = 0;
    int          ready_viol = 0;
    logic [31:0] h0_seen = 32'h0;
    int          dly = 0;
    bit          hold = 1'b0;
    bit          hold_go = 1'b0;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic compress();
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = cur[t];
        for (int t = 16; t < 64; t++) begin
            w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
                 + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
        end
        a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
        e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
        hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
    endtask

    // done: stays high through GAP, drops, then rises a few cycles after go.
    always @(posedge clk) begin
        if (core_init) begin
            done <= 1'b0;
            dly  <= 0;
        end else if (go) begin
            dly <= 4;
        end else if (dly != 0) begin
            dly <= dly - 1;
            if (dly == 4) done <= 1'b0;
            if (dly == 1) done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chipselect || write) begin
            check_eq("cs_eq_wr", 64'(chipselect), 64'(write));
            check_eq("addr_seq", 64'(address), 64'(wr_cnt % 16));
            cur[address] = writedata;
            wr_cnt++;
            if (address == 4'd15) begin
                hold    = 1'b1;
                hold_go = 1'b0;
            end
        end
        if (hold) begin
            if (in_ready) ready_viol++;
            if (go) hold_go = 1'b1;
            if (hold_go && done && dly == 0) hold = 1'b0;
        end
        if (core_init) begin
            for (int i = 0; i < 8; i++) hh[i] = IV[i];
            init_cnt++;
        end
        if (go) begin
            for (int i = 0; i < 16; i++) blocks[go_cnt % 2][i] = cur[i];
            compress();
            go_cnt++;
        end
        if (digest_valid) begin
            dv_cnt++;
            h0_seen = hh[0];
        end
    end

    function automatic logic [31:0] or_range(input int b, input int lo, input int hi);
        logic [31:0] r = 32'h0;
        for (int i = lo; i <= hi; i++) r |= blocks[b][i];
        return r;
    endfunction

    task automatic reset_model();
        wr_cnt = 0; go_cnt = 0; dv_cnt = 0; init_cnt = 0; ready_viol = 0;
        hold = 1'b0; h0_seen = 32'h0;
        for (int b = 0; b < 2; b++) for (int i = 0; i < 16; i++) blocks[b][i] = 32'hdead_beef;
    endtask

    task automatic start_msg(input bit empty);
        reset_model();
        @(negedge clk);
        start = 1'b1;
        msg_empty = empty;
        @(negedge clk);
        start = 1'b0;
        msg_empty = 1'b0;
    endtask

    task automatic feed(input int n, input bit toggle);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 1000) begin
            @(negedge clk);
            in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            in_data  = msg[idx];
            in_last  = (idx == n - 1);
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        if (idx < n) check_eq("feed_timeout", 64'(idx), 64'(n));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_dv();
        int budget = 0;
        while (dv_cnt == 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check_eq("dv_seen", 64'(dv_cnt != 0), 64'd1);
        repeat (3) @(negedge clk);
        check_eq("idle_after", 64'(busy), 64'd0);
    endtask

    task automatic run_msg(input int n, input bit toggle);
        start_msg(n == 0);
        if (n != 0) feed(n, toggle);
        wait_dv();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq(tag, {21'h0, busy, in_ready, core_init, chipselect, write, go, digest_valid,
                       address, writedata}, 64'h0);
    endtask

    task automatic load_abc();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    endtask

    initial begin
        int budget;
        for (int i = 0; i < 8; i++) hh[i] = 32'h0;
        for (int i = 0; i < 16; i++) cur[i] = 32'h0;
        reset_model();
        #1;
        check_outputs_zero("reset_outputs");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("post_reset_idle");

        // "abc"
        load_abc();
        run_msg(3, 1'b0);
        check_eq("abc_init", 64'(init_cnt), 64'd1);
        check_eq("abc_writes", 64'(wr_cnt), 64'd16);
        check_eq("abc_go", 64'(go_cnt), 64'd1);
        check_eq("abc_dv", 64'(dv_cnt), 64'd1);
        check_eq("abc_w0", 64'(blocks[0][0]), 64'h61626380);
        check_eq("abc_w1_14", 64'(or_range(0, 1, 14)), 64'h0);
        check_eq("abc_w15", 64'(blocks[0][15]), 64'h18);
        check_eq("abc_h0", 64'(h0_seen), 64'hba7816bf);

        // empty message
        run_msg(0, 1'b0);
        check_eq("empty_go", 64'(go_cnt), 64'd1);
        check_eq("empty_w0", 64'(blocks[0][0]), 64'h80000000);
        check_eq("empty_w1_15", 64'(or_range(0, 1, 15)), 64'h0);
        check_eq("empty_h0", 64'(h0_seen), 64'he3b0c442);

        // 55 bytes: length still fits in the same block
        for (int i = 0; i < 64; i++) msg[i] = 8'h41;
        run_msg(55, 1'b0);
        check_eq("b55_go", 64'(go_cnt), 64'd1);
        check_eq("b55_w13", 64'(blocks[0][13]), 64'h41414180);
        check_eq("b55_w14", 64'(blocks[0][14]), 64'h0);
        check_eq("b55_w15", 64'(blocks[0][15]), 64'h1B8);

        // 56 bytes: marker in word 14, length spills into a second block
        run_msg(56, 1'b0);
        check_eq("b56_go", 64'(go_cnt), 64'd2);
        check_eq("b56_dv", 64'(dv_cnt), 64'd1);
        check_eq("b56_writes", 64'(wr_cnt), 64'd32);
        check_eq("b56_b1w13", 64'(blocks[0][13]), 64'h41414141);
        check_eq("b56_b1w14", 64'(blocks[0][14]), 64'h80000000);
        check_eq("b56_b1w15", 64'(blocks[0][15]), 64'h0);
        check_eq("b56_b2w0_14", 64'(or_range(1, 0, 14)), 64'h0);
        check_eq("b56_b2w15", 64'(blocks[1][15]), 64'h1C0);

        // 64 bytes with a gappy source: padding is a whole block
        run_msg(64, 1'b1);
        check_eq("b64_go", 64'(go_cnt), 64'd2);
        check_eq("b64_writes", 64'(wr_cnt), 64'd32);
        check_eq("b64_b1w15", 64'(blocks[0][15]), 64'h41414141);
        check_eq("b64_b2w0", 64'(blocks[1][0]), 64'h80000000);
        check_eq("b64_b2w1_14", 64'(or_range(1, 1, 14)), 64'h0);
        check_eq("b64_b2w15", 64'(blocks[1][15]), 64'h200);
        check_eq("b64_ready_hold", 64'(ready_viol), 64'd0);

        // reset during WAIT of "abc"
        load_abc();
        start_msg(1'b0);
        feed(3, 1'b0);
        budget = 0;
        while (go_cnt == 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check_eq("abort_go_seen", 64'(go_cnt), 64'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("abort_outputs");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("abort_no_go", 64'(go_cnt), 64'd1);
        check_eq("abort_no_dv", 64'(dv_cnt), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        run_msg(3, 1'b0);
        check_eq("rerun_init", 64'(init_cnt), 64'd1);
        check_eq("rerun_go", 64'(go_cnt), 64'd1);
        check_eq("rerun_h0", 64'(h0_seen), 64'hba7816bf);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sha256_msg_feeder.md
Name: sha256_msg_feeder

Overview:
- Host-side initiator for the SHA-256 round core's write/go/done interface.
- Accepts a byte stream for one message and applies standard SHA-256 padding (0x80 byte, zero fill, 64-bit big-endian bit length).
- Writes each 512-bit block as 16 words through chipselect/write/address/writedata, then pulses go and waits for done.
- Reports when the final digest on the core's h0..h7 outputs is valid.

Parameters:
- LEN_W, 32: width of the message byte counter. The bit length sent to the core is {zero-extend(byte_count), 3'b000} truncated to 64 bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a new message; honoured only in IDLE
- msg_empty  in  1  sampled with start; 1 = zero-length message
- in_data  in  8  message byte
- in_valid  in  1  byte valid
- in_last  in  1  qualifies the final byte of the message
- in_ready  out  1  byte accepted when in_valid && in_ready
- core_init  out  1  one-cycle pulse; drives the core's synchronous reset, which reloads the H constants
- chipselect  out  1  core write strobe, asserted together with write
- write  out  1  core write
- address  out  4  word index 0..15
- writedata  out  32  word; first byte in [31:24]
- go  out  1  one-cycle start pulse to the core
- done  in  1  core done; sticky high until the next go
- busy  out  1  high whenever the state is not IDLE
- digest_valid  out  1  one-cycle pulse; core h0..h7 hold the final digest

Behaviour:
- Reset: all outputs are 0, state = IDLE, counters are 0. Reset mid-message aborts with no further writes or go. The core is re-initialised by the next start.
- State sequence: IDLE -> INIT -> LOAD -> PAD -> GO -> GAP -> WAIT -> (LOAD | PAD | DONE) -> IDLE.
- IDLE: in_ready=0. On start, clear byte_count and word index, latch msg_empty, and go to INIT. start in any other state is ignored.
- INIT: core_init=1 for exactly one cycle. Next state is PAD if msg_empty, otherwise LOAD.
- LOAD:
  - in_ready=1.
  - Bytes shift into a 32-bit packer, big-endian.
  - On the 4th byte of a word, the next cycle drives chipselect=write=1 with address=word index and writedata=packed word, and the word index increments.
  - Byte acceptance continues in parallel, so there is at most one write per cycle.
  - After word 15 is written, in_ready drops and the state goes to GO. The next block resumes in LOAD after WAIT.
  - Accepting the byte with in_last goes to PAD.
- PAD:
  - in_ready=0.
  - Let k = byte_count mod 64. The current partial word is completed with 0x80 and then zeros; further zero words follow.
  - If k <= 55: word 14 = length[63:32], word 15 = length[31:0], then GO with final=1.
  - If k >= 56: zero-fill through word 15, then GO with final=0. After WAIT, a second padded block follows: words 0..13 = 0, 14/15 = length, final=1.
  - One word is written per cycle.
- GO: go=1 for one cycle, issued the cycle after the word-15 write.
- GAP: one cycle. done is ignored here because it still reflects the previous block.
- WAIT: hold until done==1.
  - final=1 goes to DONE.
  - Pending pad block goes to PAD.
  - Otherwise, reset the word index to 0 and go to LOAD.
- DONE: digest_valid=1 for one cycle, then IDLE.
- in_valid while in_ready=0 is held off by the source. No data is lost.
- byte_count wraps modulo 2^LEN_W. Longer messages are unsupported.
- Message byte 0 always lands at word 0 bits [31:24].

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) -> one block: word0=0x61626380, words 1..14 = 0, word15=0x00000018; one go; digest_valid after done, core h0=0xba7816bf.
- Empty message (start, msg_empty=1) -> word0=0x80000000, words 1..15 = 0; digest h0=0xe3b0c442.
- 55 bytes of 0x41 -> one block: word13=0x41414180, word15=0x000001B8; exactly one go.
- 56 bytes of 0x41 -> two blocks: block 1 word14=0x80000000, word15=0; block 2 words 0..13 = 0, word15=0x000001C0; two go pulses; digest_valid once.
- 64 bytes with in_valid toggling every other cycle -> 16 writes with correct addresses; in_ready=0 from word-15 write through WAIT; second block is pure padding with word0=0x80000000 and word15=0x00000200.
- reset_n low during WAIT of "abc" -> outputs are 0 immediately. A new start issues core_init and produces the correct "abc" digest.
